// File: rtl/id_cycle.sv
// Instruction-decode stage: IF/ID register, decoder, 32x32 register file with
// write-through bypass, load-use hazard detection and the ID/EX register.
module id_cycle #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  inputPC,
  input  logic [31:0] IR,
  input  logic        flush,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic        id_valid,
  output logic [9:0]  id_pc,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] imm_ext,
  output logic [4:0]  dest_reg,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic        is_branch,
  output logic        is_jump,
  output logic [1:0]  alu_op,
  output logic [9:0]  branch_target,
  output logic        illegal
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  typedef struct packed {
    logic        valid;
    logic [9:0]  pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic        is_branch;
    logic        is_jump;
    logic [1:0]  alu_op;
    logic [9:0]  target;
    logic        illegal;
  } idex_t;

  logic [31:0] ifid_ir_q, ifid_ir_d;
  logic [9:0]  ifid_pc_q, ifid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] rf_q [32];
  idex_t       idex_q, idex_d;

  opcode_e     opcode;
  logic [4:0]  rs_a, rt_a, rd_a;
  logic [31:0] imm_w, rs_val, rt_val;
  logic        uses_rt;

  assign opcode = opcode_e'(ifid_ir_q[31:26]);
  assign rs_a   = ifid_ir_q[25:21];
  assign rt_a   = ifid_ir_q[20:16];
  assign rd_a   = ifid_ir_q[15:11];
  assign imm_w  = {{16{ifid_ir_q[15]}}, ifid_ir_q[15:0]};

  // r0 is cleared on reset and never written, so it needs no special read case
  assign rs_val = (wb_en && wb_addr == rs_a && rs_a != '0) ? wb_data : rf_q[rs_a];
  assign rt_val = (wb_en && wb_addr == rt_a && rt_a != '0) ? wb_data : rf_q[rt_a];

  assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  assign stall   = ex_mem_read & ifid_valid_q & (ex_rd != '0) &
                   ((ex_rd == rs_a) | ((ex_rd == rt_a) & uses_rt));

  always_comb begin
    ifid_ir_d    = ifid_ir_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    if (reset || flush) begin
      ifid_ir_d    = NOP_WORD;
      ifid_pc_d    = '0;
      ifid_valid_d = 1'b0;
    end else if (!stall) begin
      ifid_ir_d    = IR;
      ifid_pc_d    = inputPC;
      ifid_valid_d = 1'b1;
    end
  end

  always_comb begin
    idex_d         = '0;
    idex_d.valid   = ifid_valid_q;
    idex_d.pc      = ifid_pc_q;
    idex_d.rs_data = rs_val;
    idex_d.rt_data = rt_val;
    idex_d.imm     = imm_w;
    idex_d.rs_addr = rs_a;
    idex_d.rt_addr = rt_a;
    // (imm << 2) truncated to 10 bits only keeps imm[7:0]
    idex_d.target  = ifid_pc_q + 10'd4 + {imm_w[7:0], 2'b00};
    case (opcode)
      OP_RTYPE: begin
        idex_d.reg_write = 1'b1;
        idex_d.alu_op    = 2'b10;
        idex_d.dest      = rd_a;
      end
      OP_ADDI: begin
        idex_d.reg_write = 1'b1;
        idex_d.alu_src   = 1'b1;
        idex_d.dest      = rt_a;
      end
      OP_LW: begin
        idex_d.reg_write = 1'b1;
        idex_d.mem_read  = 1'b1;
        idex_d.alu_src   = 1'b1;
        idex_d.dest      = rt_a;
      end
      OP_SW: begin
        idex_d.mem_write = 1'b1;
        idex_d.alu_src   = 1'b1;
      end
      OP_BEQ: begin
        idex_d.is_branch = 1'b1;
        idex_d.alu_op    = 2'b01;
      end
      OP_J: begin
        idex_d.is_jump = 1'b1;
        idex_d.target  = {ifid_ir_q[7:0], 2'b00};
      end
      default: idex_d.illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    ifid_ir_q    <= ifid_ir_d;
    ifid_pc_q    <= ifid_pc_d;
    ifid_valid_q <= ifid_valid_d;
    if (reset || flush || stall) idex_q <= '0;
    else                         idex_q <= idex_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_en && wb_addr != '0) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  assign id_valid      = idex_q.valid;
  assign id_pc         = idex_q.pc;
  assign rs_data       = idex_q.rs_data;
  assign rt_data       = idex_q.rt_data;
  assign imm_ext       = idex_q.imm;
  assign dest_reg      = idex_q.dest;
  assign rs_addr       = idex_q.rs_addr;
  assign rt_addr       = idex_q.rt_addr;
  assign reg_write     = idex_q.reg_write;
  assign mem_read      = idex_q.mem_read;
  assign mem_write     = idex_q.mem_write;
  assign alu_src       = idex_q.alu_src;
  assign is_branch     = idex_q.is_branch;
  assign is_jump       = idex_q.is_jump;
  assign alu_op        = idex_q.alu_op;
  assign branch_target = idex_q.target;
  assign illegal       = idex_q.illegal;

endmodule

// File: tb/tb_id_cycle.sv
// Self-checking bench for id_cycle: directed scenarios plus a randomized run,
// all compared against a cycle-level behavioural model of the decode stage.
module tb_id_cycle;

  logic        clk = 1'b0;
  logic        reset, flush, ex_mem_read, wb_en;
  logic [9:0]  inputPC;
  logic [31:0] IR, wb_data;
  logic [4:0]  ex_rd, wb_addr;
  logic        stall, id_valid, reg_write, mem_read, mem_write, alu_src;
  logic        is_branch, is_jump, illegal;
  logic [9:0]  id_pc, branch_target;
  logic [31:0] rs_data, rt_data, imm_ext;
  logic [4:0]  dest_reg, rs_addr, rt_addr;
  logic [1:0]  alu_op;

  typedef struct packed {
    logic        valid;
    logic [9:0]  pc;
    logic [31:0] rs, rt, imm;
    logic [4:0]  dest, rsa, rta;
    logic        rw, mr, mw, as, br, jp;
    logic [1:0]  op;
    logic [9:0]  bt;
    logic        ill;
  } bundle_t;

  bundle_t act, exp_b;
  assign act = {id_valid, id_pc, rs_data, rt_data, imm_ext, dest_reg, rs_addr, rt_addr,
                reg_write, mem_read, mem_write, alu_src, is_branch, is_jump, alu_op,
                branch_target, illegal};

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [31:0] m_if_ir = '0;
  logic [9:0]  m_if_pc = '0;
  logic        m_if_valid = 1'b0;
  logic [31:0] m_rf [32];

  id_cycle #(.NOP_WORD(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .inputPC(inputPC), .IR(IR), .flush(flush),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .stall(stall), .id_valid(id_valid), .id_pc(id_pc),
    .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext), .dest_reg(dest_reg),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .alu_src(alu_src), .is_branch(is_branch), .is_jump(is_jump),
    .alu_op(alu_op), .branch_target(branch_target), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r_type(int rs, int rt, int rd);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] i_type(int op, int rs, int rt, logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] read_reg(int r);
    if (r == 0) return 32'd0;
    if (wb_en && int'(wb_addr) == r) return wb_data;
    return m_rf[r];
  endfunction

  function automatic logic m_stall();
    int op = int'(m_if_ir[31:26]);
    int rs = int'(m_if_ir[25:21]);
    int rt = int'(m_if_ir[20:16]);
    int er = int'(ex_rd);
    bit uses_rt = (op == 0) || (op == 43) || (op == 4);
    return ex_mem_read && m_if_valid && er != 0 && (er == rs || (er == rt && uses_rt));
  endfunction

  function automatic bundle_t ref_decode();
    bundle_t b = '0;
    int op  = int'(m_if_ir[31:26]);
    int rs  = int'(m_if_ir[25:21]);
    int rt  = int'(m_if_ir[20:16]);
    int off = int'($signed(m_if_ir[15:0]));
    int tgt = (int'(m_if_pc) + 4 + off * 4) % 1024;
    if (tgt < 0) tgt += 1024;
    b.valid = m_if_valid;
    b.pc  = m_if_pc;
    b.rsa = 5'(rs);
    b.rta = 5'(rt);
    b.rs  = read_reg(rs);
    b.rt  = read_reg(rt);
    b.imm = 32'(off);
    b.bt  = 10'(tgt);
    case (op)
      0:  begin b.rw = 1; b.op = 2'd2; b.dest = m_if_ir[15:11]; end
      8:  begin b.rw = 1; b.as = 1; b.dest = 5'(rt); end
      35: begin b.rw = 1; b.mr = 1; b.as = 1; b.dest = 5'(rt); end
      43: begin b.mw = 1; b.as = 1; end
      4:  begin b.br = 1; b.op = 2'd1; end
      2:  begin b.jp = 1; b.bt = 10'(int'(m_if_ir[7:0]) * 4); end
      default: b.ill = 1;
    endcase
    return b;
  endfunction

  // Advance one clock: model predicts from the inputs held across the edge.
  task automatic tick();
    bundle_t nb;
    logic st;
    st = m_stall();
    if (reset || flush || st) nb = '0;
    else                      nb = ref_decode();
    @(posedge clk);
    exp_b = nb;
    if (reset || flush) begin
      m_if_ir = 32'h0; m_if_pc = '0; m_if_valid = 1'b0;
    end else if (!st) begin
      m_if_ir = IR; m_if_pc = inputPC; m_if_valid = 1'b1;
    end
    if (reset) begin
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
    end else if (wb_en && wb_addr != 0) begin
      m_rf[wb_addr] = wb_data;
    end
    #1;
  endtask

  task automatic idle();
    reset = 0; flush = 0; ex_mem_read = 0; ex_rd = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1; IR = i_type(8, 0, 1, 16'd5); inputPC = 10'd12;
    tick(); tick();
    chk_cnt++;
    if (act !== '0) $display("FAIL reset_outputs: got %h want 0", act);
    else pass_cnt++;
    chk_cnt++;
    if (stall !== 1'b0 || id_valid !== 1'b0)
      $display("FAIL reset_stall_valid: got stall=%b valid=%b want 0 0", stall, id_valid);
    else pass_cnt++;
    reset = 0; IR = r_type(1, 31, 3); inputPC = 10'd0;
    tick(); tick();
    chk_cnt++;
    if (rs_data !== 32'd0 || rt_data !== 32'd0 || act !== exp_b)
      $display("FAIL reset_regs_zero: got rs=%h rt=%h want 0 0 (bundle %h vs %h)",
               rs_data, rt_data, act, exp_b);
    else pass_cnt++;
  endtask

  task automatic test_decode();
    idle();
    wb_en = 1; wb_addr = 2; wb_data = 32'd7; IR = 32'h0; inputPC = 10'd0;
    tick();
    wb_en = 0; IR = i_type(8, 2, 3, 16'hFFFF); inputPC = 10'd8;
    tick(); tick();
    chk_cnt++;
    if (rs_data !== 32'd7 || imm_ext !== 32'hFFFF_FFFF || dest_reg !== 5'd3 ||
        reg_write !== 1'b1 || alu_src !== 1'b1 || id_pc !== 10'd8 || id_valid !== 1'b1)
      $display("FAIL decode_addi: got rs=%h imm=%h dest=%0d rw=%b as=%b pc=%0d v=%b want 7 ffffffff 3 1 1 8 1",
               rs_data, imm_ext, dest_reg, reg_write, alu_src, id_pc, id_valid);
    else pass_cnt++;
    chk_cnt++;
    if (act !== exp_b) $display("FAIL decode_model: got %h want %h", act, exp_b);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    idle();
    IR = r_type(4, 0, 7); inputPC = 10'd16;
    tick();
    wb_en = 1; wb_addr = 4; wb_data = 32'h0000_ABCD; IR = 32'h0;
    tick();
    chk_cnt++;
    if (rs_data !== 32'h0000_ABCD || act !== exp_b)
      $display("FAIL bypass_rs: got %h want 0000abcd", rs_data);
    else pass_cnt++;
    wb_addr = 0; wb_data = 32'h55; IR = r_type(0, 0, 8); inputPC = 10'd20;
    tick(); tick();
    chk_cnt++;
    if (rs_data !== 32'd0 || act !== exp_b)
      $display("FAIL r0_write_ignored: got %h want 0", rs_data);
    else pass_cnt++;
    wb_en = 0;
  endtask

  task automatic test_load_use();
    idle();
    IR = r_type(5, 1, 6); inputPC = 10'd24;
    tick();
    ex_mem_read = 1; ex_rd = 5; IR = i_type(8, 1, 9, 16'd3); inputPC = 10'd28;
    #1;
    chk_cnt++;
    if (stall !== 1'b1) $display("FAIL load_use_stall: got %b want 1", stall);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (id_valid !== 1'b0 || act !== exp_b)
      $display("FAIL load_use_bubble: got %h want %h", act, exp_b);
    else pass_cnt++;
    ex_mem_read = 0; ex_rd = 0;
    #1;
    chk_cnt++;
    if (stall !== 1'b0) $display("FAIL load_use_one_cycle: got %b want 0", stall);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (id_valid !== 1'b1 || rs_addr !== 5'd5 || id_pc !== 10'd24 || act !== exp_b)
      $display("FAIL load_use_reissue: got v=%b rs=%0d pc=%0d want 1 5 24", id_valid, rs_addr, id_pc);
    else pass_cnt++;
    ex_mem_read = 1; ex_rd = 0;
    #1;
    chk_cnt++;
    if (stall !== 1'b0) $display("FAIL ex_rd_zero: got %b want 0", stall);
    else pass_cnt++;
    ex_rd = 9;
    #1;
    chk_cnt++;
    if (stall !== 1'b0) $display("FAIL addi_rt_no_stall: got %b want 0", stall);
    else pass_cnt++;
    idle();
  endtask

  task automatic test_flush();
    idle();
    IR = r_type(5, 5, 10); inputPC = 10'd40;
    tick();
    ex_mem_read = 1; ex_rd = 5; flush = 1; IR = i_type(8, 0, 11, 16'd1); inputPC = 10'd44;
    #1;
    chk_cnt++;
    if (stall !== 1'b1) $display("FAIL flush_setup_stall: got %b want 1", stall);
    else pass_cnt++;
    tick();
    idle();
    #1;
    chk_cnt++;
    if (id_valid !== 1'b0 || stall !== 1'b0 || act !== exp_b)
      $display("FAIL flush_kill: got v=%b stall=%b want 0 0", id_valid, stall);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (id_valid !== 1'b0) $display("FAIL flush_discard: got %b want 0", id_valid);
    else pass_cnt++;
  endtask

  task automatic test_branch();
    idle();
    IR = i_type(4, 1, 2, 16'hFFFE); inputPC = 10'd4;
    tick();
    IR = i_type(4, 3, 4, 16'h0001); inputPC = 10'd1020;
    tick();
    chk_cnt++;
    if (branch_target !== 10'd0 || is_branch !== 1'b1 || alu_op !== 2'b01 || act !== exp_b)
      $display("FAIL beq_back: got bt=%0d br=%b op=%b want 0 1 01", branch_target, is_branch, alu_op);
    else pass_cnt++;
    IR = {6'h3F, 26'h2AB_CDEF}; inputPC = 10'd100;
    tick();
    chk_cnt++;
    if (branch_target !== 10'd4 || act !== exp_b)
      $display("FAIL beq_wrap: got %0d want 4", branch_target);
    else pass_cnt++;
    IR = {6'h02, 26'h00000AB}; inputPC = 10'd104;
    tick();
    chk_cnt++;
    if (illegal !== 1'b1 || {reg_write, mem_read, mem_write, alu_src, is_branch, is_jump, alu_op} !== 8'd0)
      $display("FAIL illegal_op: got ill=%b ctl=%b want 1 00000000", illegal,
               {reg_write, mem_read, mem_write, alu_src, is_branch, is_jump, alu_op});
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (is_jump !== 1'b1 || branch_target !== 10'h2AC || act !== exp_b)
      $display("FAIL jump_target: got j=%b bt=%h want 1 2ac", is_jump, branch_target);
    else pass_cnt++;
  endtask

  function automatic logic [31:0] rand_ir();
    int ops [7] = '{0, 8, 35, 43, 4, 2, 63};
    int op = ops[$urandom_range(0, 6)];
    if (op == 0) return r_type($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
    return i_type(op, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
  endfunction

  task automatic test_random();
    int errs = 0;
    for (int n = 0; n < 400; n++) begin
      reset       = ($urandom_range(0, 49) == 0);
      flush       = ($urandom_range(0, 15) == 0);
      ex_mem_read = ($urandom_range(0, 2) == 0);
      ex_rd       = 5'($urandom_range(0, 7));
      wb_en       = $urandom_range(0, 1);
      wb_addr     = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      IR          = rand_ir();
      inputPC     = 10'($urandom);
      #1;
      chk_cnt++;
      if (stall !== m_stall()) begin
        if (errs < 10) $display("FAIL rand_stall[%0d]: got %b want %b", n, stall, m_stall());
        errs++;
      end else pass_cnt++;
      tick();
      chk_cnt++;
      if (act !== exp_b) begin
        if (errs < 10) $display("FAIL rand_bundle[%0d]: got %h want %h", n, act, exp_b);
        errs++;
      end else pass_cnt++;
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    idle();
    IR = '0; inputPC = '0;
    test_reset();
    test_decode();
    test_bypass();
    test_load_use();
    test_flush();
    test_branch();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/id_cycle.md
# id_cycle

Instruction-decode stage of the 5-stage pipeline, directly downstream of the fetch stage. It latches the fetched instruction and PC (IF/ID register), decodes the instruction, and reads operands from a 32×32 register file with a write-back port. It detects load-use hazards and issues stalls, and it registers the decoded bundle into the ID/EX register for the execute stage.

## Interface
Parameters:
- `NOP_WORD`, default 32'h0000_0000: instruction word inserted as a bubble.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `inputPC`: input, 10 bits. PC of the fetched instruction, from fetch.
- `IR`: input, 32 bits. Fetched instruction word.
- `flush`: input, 1 bit. Branch or jump taken in EX; kill the IF/ID and ID/EX contents.
- `ex_mem_read`: input, 1 bit. The instruction currently in EX is a load.
- `ex_rd`: input, 5 bits. Destination register of the instruction in EX.
- `wb_en`: input, 1 bit. Register-file write enable from WB.
- `wb_addr`: input, 5 bits. Write address.
- `wb_data`: input, 32 bits. Write data.
- `stall`: output, 1 bit. Combinational. Fetch must hold its PC and IR while this is high.
- `id_valid`: output, 1 bit. ID/EX holds a real instruction.
- `id_pc`: output, 10 bits. PC of that instruction.
- `rs_data`, `rt_data`: output, 32 bits each. Operand values.
- `imm_ext`: output, 32 bits. Sign-extended `IR[15:0]`.
- `dest_reg`: output, 5 bits. rd for R-type; rt for ADDI and LW; 0 otherwise.
- `rs_addr`, `rt_addr`: output, 5 bits each. Forwarded to the EX forwarding unit.
- `reg_write`, `mem_read`, `mem_write`, `alu_src`, `is_branch`, `is_jump`: output, 1 bit each. Control signals.
- `alu_op`: output, 2 bits. 00 add, 01 sub (BEQ), 10 funct-decoded (R-type).
- `branch_target`: output, 10 bits. `id_pc + 4 + (imm_ext << 2)`, truncated to 10 bits. For J: `{IR[7:0], 2'b00}`.
- `illegal`: output, 1 bit. The ID/EX entry came from an unrecognised opcode.

## Operation
- Instruction fields: opcode `IR[31:26]`, rs `[25:21]`, rt `[20:16]`, rd `[15:11]`, imm `[15:0]`.
- Opcode decode:
  - 000000 R-type: reg_write, alu_op=10.
  - 001000 ADDI: reg_write, alu_src.
  - 100011 LW: reg_write, mem_read, alu_src.
  - 101011 SW: mem_write, alu_src.
  - 000100 BEQ: is_branch, alu_op=01.
  - 000010 J: is_jump.
  - Any other opcode: all control signals 0, `illegal`=1.
- An all-zero word is a NOP: valid R-type with rd=0. The register-write path ignores it.
- IF/ID register, priority order:
  1. reset or flush: load bubble (`NOP_WORD`, PC 0, valid 0).
  2. stall: hold current contents.
  3. Otherwise: capture `inputPC` and `IR` with valid=1.
- Register file:
  - 32 entries; r0 reads as 0, and writes to r0 are discarded.
  - Written on the rising edge when `wb_en` is high.
  - Reads are combinational with write-through bypass: if `wb_en` is high and `wb_addr` matches a nonzero read address in the same cycle, that read returns `wb_data`.
- Load-use hazard: `stall` = `ex_mem_read` & IF/ID valid & `ex_rd`≠0 & (`ex_rd`==rs | (`ex_rd`==rt & opcode ∈ {R-type, SW, BEQ})).
- ID/EX register, priority order:
  1. reset or flush: all outputs 0.
  2. stall: insert a bubble (all outputs 0). IF/ID holds, so the instruction is re-decoded next cycle.
  3. Otherwise: capture the decoded bundle, with `id_valid` = IF/ID valid.

## Timing
- Reset (synchronous): after the first rising edge with reset high, every output is 0, IF/ID holds a bubble, and all 32 registers are 0. `stall` is 0 after that edge.
- Latency: an instruction captured into IF/ID at edge k appears on the ID/EX outputs after edge k+1. Throughput is 1 instruction per cycle when there is no stall.
- A load-use stall lasts exactly 1 cycle, because on the next edge the load leaves EX and the EX inputs show a bubble.
- `flush` together with `stall`: flush wins. Both registers are emptied and IF/ID does not hold.
- `reset` together with `flush` or `wb_en`: reset wins, and the register-file write is discarded.
- Reset asserted mid-stream: in-flight instructions are lost and nothing is written.
- PC arithmetic is modulo 2^10: `branch_target` wraps, e.g. PC 1020 + 4 = 0.

## Test plan
- **Reset:** hold reset 2 cycles with IR=ADDI r1,r0,5 driven. All outputs are 0 and `id_valid`=0; a read of any register afterwards returns 0.
- **Decode and forward-through:** WB writes r2=7. Then drive ADDI r3,r2,-1 at PC 8. One edge later: rs_data=7, imm_ext=FFFF_FFFF, dest_reg=3, reg_write=1, alu_src=1, id_pc=8.
- **Same-cycle bypass:** `wb_en` with r4=0xABCD while an R-type reading r4 is decoded. `rs_data`=0xABCD. A write to r0 with 0x55 reads back 0.
- **Load-use:** EX has LW to r5 (`ex_mem_read`=1, `ex_rd`=5) while IF/ID holds ADD r6,r5,r1. `stall`=1 for exactly 1 cycle, ID/EX shows a bubble, and the ADD is issued on the following edge. `ex_rd`=0 gives no stall.
- **Flush:** assert `flush` together with a stall condition. Next edge: `id_valid`=0, `stall`=0, and the fetched instruction is discarded.
- **Branch target and illegal:** BEQ with imm=-2 at PC 4 gives `branch_target`=0. BEQ with imm=+1 at PC 1020 gives 4 (wraparound). Opcode 111111 gives `illegal`=1 with all control signals 0.
